bin2bcd_seq_hs: RTL and testbench

Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble), one input bit per cycle, so latency is deterministic rather than value-dependent.
- Supports unsigned and two's-complement input, selected per transaction.
- Reports sign, overflow (value too large for DIGITS digits) and the count of significant digits.
- Uses valid/ready handshakes on both sides, so it sits directly between a binary datapath and display/formatting logic.

---
 rtl/bin2bcd_seq_hs.sv | 153 +++++++++++++++
 tb/tb_bin2bcd_seq_hs.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq_hs.sv
// Sequential binary to packed-BCD converter (double dabble, one bit per cycle).
// Handles unsigned or two's-complement input; reports sign, overflow and digit count.
module bin2bcd_seq_hs #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIN_W-1:0]             in_data,
  input  logic                         in_signed,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          out_bcd,
  output logic                         out_neg,
  output logic                         out_ovf,
  output logic [$clog2(DIGITS+1)-1:0]  out_ndigits
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam int NW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINAL,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [BIN_W-1:0] mag_q, mag_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            ovf_q, ovf_d;
  logic            ov_q, ov_d;
  logic [AW-1:0]   ob_q, ob_d;
  logic            on_q, on_d;
  logic            oo_q, oo_d;
  logic [NW-1:0]   nd_q, nd_d;

  logic [AW-1:0]   acc_adj;
  logic [NW-1:0]   nd_calc;
  logic            in_neg;

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = ov_q;
  assign out_bcd     = ob_q;
  assign out_neg     = on_q;
  assign out_ovf     = oo_q;
  assign out_ndigits = nd_q;

  assign in_neg = in_signed & in_data[BIN_W-1];

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Highest nonzero digit decides the count; zero still shows one digit.
  always_comb begin
    nd_calc = NW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] != 4'd0)
        nd_calc = NW'(i + 1);
    end
    if (ovf_q)
      nd_calc = NW'(DIGITS);
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    ov_d    = ov_q;
    ob_d    = ob_q;
    on_d    = on_q;
    oo_d    = oo_q;
    nd_d    = nd_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mag_d   = in_neg ? (BIN_W'(0) - in_data) : in_data;
          neg_d   = in_neg;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(BIN_W);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = {acc_adj[AW-2:0], mag_q[BIN_W-1]};
        mag_d = {mag_q[BIN_W-2:0], 1'b0};
        ovf_d = ovf_q | acc_adj[AW-1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = S_FINAL;
      end
      S_FINAL: begin
        ob_d    = acc_q;
        on_d    = neg_q;
        oo_d    = ovf_q;
        nd_d    = nd_calc;
        ov_d    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
      ob_q    <= '0;
      on_q    <= 1'b0;
      oo_q    <= 1'b0;
      nd_q    <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
      ob_q    <= ob_d;
      on_q    <= on_d;
      oo_q    <= oo_d;
      nd_q    <= nd_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq_hs.sv
// Directed bench for bin2bcd_seq_hs: default 32/10 instance and a 10/3 instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bin2bcd_seq_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_is, a_ov, a_or, a_neg, a_ovf;
  logic [31:0] a_id;
  logic [39:0] a_bcd;
  logic [3:0]  a_nd;

  logic        b_iv, b_ir, b_is, b_ov, b_or, b_neg, b_ovf;
  logic [9:0]  b_id;
  logic [11:0] b_bcd;
  logic [1:0]  b_nd;

  int total = 0;
  int passed = 0;
  int failed = 0;

  bin2bcd_seq_hs dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_signed(a_is),
    .out_valid(a_ov), .out_ready(a_or), .out_bcd(a_bcd), .out_neg(a_neg),
    .out_ovf(a_ovf), .out_ndigits(a_nd)
  );

  bin2bcd_seq_hs #(.BIN_W(10), .DIGITS(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_signed(b_is),
    .out_valid(b_ov), .out_ready(b_or), .out_bcd(b_bcd), .out_neg(b_neg),
    .out_ovf(b_ovf), .out_ndigits(b_nd)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Send one word to instance A; returns edges from accept to out_valid.
  task automatic conv_a(input logic [31:0] d, input logic s, output int lat);
    @(negedge clk);
    a_id = d; a_is = s; a_iv = 1'b1;
    @(posedge clk);
    #1 a_iv = 1'b0; a_id = 32'hDEAD_BEEF; a_is = ~s;
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (a_ov) break;
      if (lat > 100) begin
        chk("a_timeout", 64'(lat), 64'd33);
        break;
      end
    end
  endtask

  task automatic conv_b(input logic [9:0] d, output int lat);
    @(negedge clk);
    b_id = d; b_is = 1'b0; b_iv = 1'b1;
    @(posedge clk);
    #1 b_iv = 1'b0; b_id = 10'h3FF;
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (b_ov) break;
      if (lat > 50) begin
        chk("b_timeout", 64'(lat), 64'd11);
        break;
      end
    end
  endtask

  task automatic take_a(input string tag);
    a_or = 1'b1;
    @(posedge clk);
    #1 a_or = 1'b0;
    chk({tag, "_ov_drop"}, 64'(a_ov), 64'd0);
    chk({tag, "_ir_back"}, 64'(a_ir), 64'd1);
  endtask

  task automatic take_b();
    b_or = 1'b1;
    @(posedge clk);
    #1 b_or = 1'b0;
  endtask

  int lat;
  logic [39:0] held;
  logic seen;

  initial begin
    a_iv = 0; a_id = 0; a_is = 0; a_or = 0;
    b_iv = 0; b_id = 0; b_is = 0; b_or = 0;
    repeat (2) @(negedge clk);
    chk("rst_ir", 64'(a_ir), 64'd1);
    chk("rst_ov", 64'(a_ov), 64'd0);
    chk("rst_bcd", 64'(a_bcd), 64'd0);
    chk("rst_nd", 64'(a_nd), 64'd0);
    chk("rst_neg_ovf", 64'({a_neg, a_ovf}), 64'd0);
    rst = 1'b0;

    conv_a(32'd0, 1'b0, lat);
    chk("u0_lat", 64'(lat), 64'd33);
    chk("u0_bcd", 64'(a_bcd), 64'd0);
    chk("u0_nd", 64'(a_nd), 64'd1);
    chk("u0_neg_ovf", 64'({a_neg, a_ovf}), 64'd0);
    take_a("u0");

    conv_a(32'hFFFF_FFFF, 1'b0, lat);
    chk("umax_bcd", 64'(a_bcd), 64'h42_9496_7295);
    chk("umax_nd", 64'(a_nd), 64'd10);
    chk("umax_ovf", 64'(a_ovf), 64'd0);
    take_a("umax");

    conv_a(32'h0000_3039, 1'b0, lat);
    chk("u12345_bcd", 64'(a_bcd), 64'h12345);
    chk("u12345_nd", 64'(a_nd), 64'd5);
    take_a("u12345");

    conv_a(32'hFFFF_FFFF, 1'b1, lat);
    chk("sm1_neg", 64'(a_neg), 64'd1);
    chk("sm1_bcd", 64'(a_bcd), 64'd1);
    chk("sm1_nd", 64'(a_nd), 64'd1);
    take_a("sm1");

    conv_a(32'h8000_0000, 1'b1, lat);
    chk("smin_neg", 64'(a_neg), 64'd1);
    chk("smin_bcd", 64'(a_bcd), 64'h21_4748_3648);
    take_a("smin");

    conv_a(32'h7FFF_FFFF, 1'b1, lat);
    chk("smax_neg", 64'(a_neg), 64'd0);
    chk("smax_bcd", 64'(a_bcd), 64'h21_4748_3647);
    take_a("smax");

    conv_a(32'd0, 1'b1, lat);
    chk("s0_neg", 64'(a_neg), 64'd0);
    take_a("s0");

    conv_b(10'd999, lat);
    chk("b999_lat", 64'(lat), 64'd11);
    chk("b999_bcd", 64'(b_bcd), 64'h999);
    chk("b999_ovf", 64'(b_ovf), 64'd0);
    take_b();
    conv_b(10'd1000, lat);
    chk("b1000_bcd", 64'(b_bcd), 64'h000);
    chk("b1000_ovf", 64'(b_ovf), 64'd1);
    chk("b1000_nd", 64'(b_nd), 64'd3);
    take_b();
    conv_b(10'd1023, lat);
    chk("b1023_bcd", 64'(b_bcd), 64'h023);
    chk("b1023_ovf", 64'(b_ovf), 64'd1);
    take_b();
    conv_b(10'd5, lat);
    chk("b5_bcd", 64'(b_bcd), 64'h005);
    chk("b5_nd", 64'(b_nd), 64'd1);
    take_b();

    // Backpressure with an ignored input pulse
    conv_a(32'd4321, 1'b0, lat);
    held = a_bcd;
    chk("bp_bcd", 64'(held), 64'h4321);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a_iv = 1'b1; a_id = 32'd777; a_is = 1'b0;
      end else begin
        a_iv = 1'b0;
      end
      @(negedge clk);
      chk("bp_stable", 64'(a_bcd), 64'(held));
      chk("bp_ov_hold", 64'(a_ov), 64'd1);
      chk("bp_ir_low", 64'(a_ir), 64'd0);
    end
    a_iv = 1'b0;
    take_a("bp");
    conv_a(32'h0000_3039, 1'b0, lat);
    chk("bp_next_bcd", 64'(a_bcd), 64'h12345);
    chk("bp_next_lat", 64'(lat), 64'd33);
    take_a("bp_next");

    // Reset in the middle of a conversion
    @(negedge clk);
    a_id = 32'd12345; a_is = 1'b0; a_iv = 1'b1;
    @(posedge clk);
    #1 a_iv = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ir", 64'(a_ir), 64'd1);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_ov) seen = 1'b1;
    end
    chk("mid_rst_no_ov", 64'(seen), 64'd0);
    chk("mid_rst_ir2", 64'(a_ir), 64'd1);
    conv_a(32'd678, 1'b0, lat);
    chk("post_rst_bcd", 64'(a_bcd), 64'h678);
    chk("post_rst_nd", 64'(a_nd), 64'd3);
    take_a("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
